fifo_unloader: RTL and testbench

//  Read-side consumer of the 9-bit packet FIFO. Pops words from the FIFO's show-ahead output
//  (data_out always equals the word at tail), strips bit[8] as an end-of-packet marker, and

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_unloader_stats.sv | 25 ++
 rtl/fifo_unloader.sv | 113 +++++++++++
 tb/tb_fifo_unloader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Definitions shared by the 9-bit packet FIFO and its read-side unloader:
// word width, end-of-packet marker position and unloader state encoding.
package fifo_pkg;
    localparam int BITSIZE = 9;
    localparam int EOP_BIT = BITSIZE - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        XFER = ST_XFER,
        DROP = ST_DROP
    } unl_state_e;
endpackage

// File: rtl/fifo_unloader_stats.sv
// Free-running packet and drop statistics; both counters wrap silently.
module fifo_unloader_stats (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pkt_inc_i,
    input  logic        drop_inc_i,
    output logic [15:0] pkt_cnt_o,
    output logic [15:0] drop_cnt_o
);
    logic [15:0] pkt_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pkt_inc_i)  pkt_cnt_q  <= pkt_cnt_q + 16'd1;
            if (drop_inc_i) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
endmodule

// File: rtl/fifo_unloader.sv
// Pops packet words from a show-ahead FIFO, strips the EOP marker bit and
// forwards payload on a registered valid/ready stream with length limiting.
module fifo_unloader
    import fifo_pkg::*;
#(
    parameter int bitsize = BITSIZE,
    parameter int MAXLEN  = 64,
    parameter int LENW    = 8
) (
    input  logic                 clk,
    input  logic                 rstp,
    input  logic                 en,
    input  logic [bitsize-1:0]   fifo_data,
    input  logic                 fifo_emptyp,
    output logic                 readp,
    output logic [bitsize-2:0]   out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 pkt_done,
    output logic [LENW-1:0]      pkt_len,
    output logic                 trunc_err,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          drop_cnt
);
    unl_state_e         state_q, state_d;
    logic [LENW-1:0]    len_cnt_q, len_cnt_d;
    logic [bitsize-2:0] out_data_q;
    logic               out_valid_q, out_last_q;
    logic               pkt_done_q, trunc_err_q;
    logic [LENW-1:0]    pkt_len_q;

    logic out_free, pop, fwd, eop, at_max, is_last, trunc, drop_inc;

    assign out_free = !out_valid_q || out_ready;
    assign eop      = fifo_data[bitsize-1];
    assign at_max   = (len_cnt_q == LENW'(MAXLEN - 1));

    always_comb begin
        pop       = 1'b0;
        state_d   = state_q;
        len_cnt_d = len_cnt_q;
        case (state_q)
            IDLE:    pop = en && !fifo_emptyp && out_free;
            XFER:    pop = !fifo_emptyp && out_free;
            DROP:    pop = !fifo_emptyp;
            default: pop = 1'b0;
        endcase
        if (rstp) pop = 1'b0;

        fwd      = pop && (state_q != DROP);
        is_last  = fwd && (eop || at_max);
        // A marker on the MAXLEN-th word wins: that packet ends cleanly.
        trunc    = is_last && !eop;
        drop_inc = pop && (state_q == DROP);

        if (fwd) begin
            if (is_last) begin
                len_cnt_d = '0;
                state_d   = eop ? IDLE : DROP;
            end else begin
                len_cnt_d = len_cnt_q + LENW'(1);
                state_d   = XFER;
            end
        end else if (drop_inc && eop) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            state_q     <= IDLE;
            len_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            trunc_err_q <= 1'b0;
            pkt_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_cnt_q   <= len_cnt_d;
            pkt_done_q  <= is_last;
            trunc_err_q <= trunc;
            if (fwd) begin
                out_data_q  <= fifo_data[bitsize-2:0];
                out_valid_q <= 1'b1;
                out_last_q  <= is_last;
                if (is_last) pkt_len_q <= len_cnt_q + LENW'(1);
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    fifo_unloader_stats u_stats (
        .clk_i      (clk),
        .rst_i      (rstp),
        .pkt_inc_i  (is_last),
        .drop_inc_i (drop_inc),
        .pkt_cnt_o  (pkt_cnt),
        .drop_cnt_o (drop_cnt)
    );

    assign readp     = pop;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_len   = pkt_len_q;
    assign trunc_err = trunc_err_q;
endmodule

// File: tb/tb_fifo_unloader.sv
// Bench for fifo_unloader: queue-based FIFO, word-stream packet parser as
// reference, directed scenarios followed by randomized traffic.
module tb_fifo_unloader;
    localparam int MAXLEN = 4;

    logic        clk;
    logic        rstp, en, fifo_emptyp, readp, out_valid, out_last, out_ready;
    logic        pkt_done, trunc_err;
    logic [8:0]  fifo_data;
    logic [7:0]  out_data, pkt_len;
    logic [15:0] pkt_cnt, drop_cnt;

    fifo_unloader #(.bitsize(9), .MAXLEN(MAXLEN), .LENW(8)) dut (
        .clk(clk), .rstp(rstp), .en(en), .fifo_data(fifo_data), .fifo_emptyp(fifo_emptyp),
        .readp(readp), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .pkt_done(pkt_done), .pkt_len(pkt_len), .trunc_err(trunc_err),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-word expectation, derived when the word enters the FIFO.
    typedef struct packed {
        logic [8:0] w;
        logic       start;
        logic       drop;
        logic       last;
        logic       trunc;
        logic [7:0] len;
    } meta_t;

    meta_t       fq[$];
    meta_t       exp_out[$];
    meta_t       prev_m;
    int          n_chk, n_err;
    int          cur_len;
    bit          in_drop, prev_pop_valid, hold_prev, exp_ov;
    int unsigned m_pkt, m_drop;
    logic [7:0]  hv_data;
    logic        hv_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_emptyp = (fq.size() == 0);
        fifo_data   = (fq.size() == 0) ? 9'($urandom) : fq[0].w;
    endtask

    task automatic push_word(input logic [8:0] w);
        meta_t m;
        m = '0;
        m.w = w;
        if (in_drop) begin
            m.drop = 1'b1;
            if (w[8]) in_drop = 1'b0;
        end else begin
            m.start = (cur_len == 0);
            cur_len++;
            if (w[8] || cur_len == MAXLEN) begin
                m.last  = 1'b1;
                m.len   = 8'(cur_len);
                m.trunc = !w[8];
                in_drop = !w[8];
                cur_len = 0;
            end
        end
        fq.push_back(m);
        drive_fifo();
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle(input bit chk_out);
        logic  exp_rd, out_free, pop, acc;
        meta_t f;
        #1;
        if (chk_out) begin
            check_eq("out_valid", out_valid, exp_ov);
            if (prev_pop_valid) begin
                check_eq("out_data", out_data, prev_m.w[7:0]);
                check_eq("out_last", out_last, prev_m.last);
                check_eq("pkt_done", pkt_done, prev_m.last);
                check_eq("trunc_err", trunc_err, prev_m.trunc);
                if (prev_m.last) check_eq("pkt_len", pkt_len, prev_m.len);
            end else begin
                check_eq("pkt_done_idle", pkt_done, 0);
                check_eq("trunc_err_idle", trunc_err, 0);
            end
            if (hold_prev) begin
                check_eq("hold_data", out_data, hv_data);
                check_eq("hold_last", out_last, hv_last);
            end
            check_eq("pkt_cnt", pkt_cnt, m_pkt[15:0]);
            check_eq("drop_cnt", drop_cnt, m_drop[15:0]);
        end
        out_free = !exp_ov || out_ready;
        if (rstp || fq.size() == 0) exp_rd = 1'b0;
        else if (fq[0].drop)        exp_rd = 1'b1;
        else if (fq[0].start)       exp_rd = en && out_free;
        else                        exp_rd = out_free;
        check_eq("readp", readp, exp_rd);

        acc = out_valid && out_ready && !rstp;
        if (acc) begin
            if (exp_out.size() == 0) check_eq("beat_extra", out_valid, 0);
            else begin
                f = exp_out.pop_front();
                check_eq("beat_data", out_data, f.w[7:0]);
                check_eq("beat_last", out_last, f.last);
            end
        end
        hold_prev = out_valid && !out_ready && !rstp;
        hv_data   = out_data;
        hv_last   = out_last;

        pop = readp && !rstp && (fq.size() > 0);
        prev_pop_valid = 1'b0;
        if (pop) begin
            f = fq.pop_front();
            if (f.drop) m_drop++;
            else begin
                prev_pop_valid = 1'b1;
                prev_m = f;
                exp_out.push_back(f);
                if (f.last) m_pkt++;
            end
        end
        if (rstp)                exp_ov = 1'b0;
        else if (prev_pop_valid) exp_ov = 1'b1;
        else if (acc)            exp_ov = 1'b0;

        @(posedge clk);
        #1;
        drive_fifo();
        @(negedge clk);
    endtask

    task automatic do_reset();
        meta_t old[$];
        old = fq;
        fq.delete();
        exp_out.delete();
        cur_len = 0; in_drop = 0; m_pkt = 0; m_drop = 0;
        prev_pop_valid = 0; hold_prev = 0; exp_ov = 0;
        foreach (old[i]) push_word(old[i].w);
        rstp = 1'b1;
        cycle(1'b0);
        cycle(1'b1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_pkt_len", pkt_len, 0);
        check_eq("rst_pkt_cnt", pkt_cnt, 0);
        check_eq("rst_drop_cnt", drop_cnt, 0);
        rstp = 1'b0;
    endtask

    task automatic drain();
        int k;
        en = 1'b1; out_ready = 1'b1;
        k = 0;
        while ((fq.size() != 0 || exp_out.size() != 0) && k < 500) begin
            cycle(1'b1);
            k++;
        end
        cycle(1'b1);
        check_eq("drain_timeout", fq.size() + exp_out.size(), 0);
    endtask

    initial begin
        int gen_left;
        logic [8:0] w;
        n_chk = 0; n_err = 0;
        rstp = 1'b1; en = 1'b0; out_ready = 1'b0;
        drive_fifo();
        @(negedge clk);

        // Reset with a word waiting, then a lone marker word.
        en = 1'b1; out_ready = 1'b1;
        push_word(9'h101);
        do_reset();
        #1;
        check_eq("t1_first_pop", readp, 1);
        cycle(1'b1);
        drain();
        check_eq("t2_pkt_cnt", pkt_cnt, 1);
        check_eq("t2_pkt_len", pkt_len, 1);
        check_eq("t2_out_data", out_data, 8'h01);

        // Backpressure for 3 cycles after the first word.
        push_word(9'h0AA); push_word(9'h0BB); push_word(9'h1CC);
        cycle(1'b1);
        out_ready = 1'b0;
        repeat (3) cycle(1'b1);
        drain();
        check_eq("t3_pkt_len", pkt_len, 3);
        check_eq("t3_pkt_cnt", pkt_cnt, 2);

        // Oversize packet: truncated at MAXLEN, remainder dropped through the marker.
        for (int i = 1; i <= 6; i++) push_word(9'(i));
        push_word(9'h1EE);
        drain();
        check_eq("t4_pkt_cnt", pkt_cnt, 3);
        check_eq("t4_pkt_len", pkt_len, 4);
        check_eq("t4_drop_cnt", drop_cnt, 3);

        // en falls mid-packet with a second packet queued.
        push_word(9'h011); push_word(9'h022); push_word(9'h133); push_word(9'h144);
        repeat (2) cycle(1'b1);
        en = 1'b0;
        repeat (8) cycle(1'b1);
        check_eq("t5_queued", fq.size(), 1);
        check_eq("t5_pkt_len", pkt_len, 3);
        drain();
        check_eq("t5_pkt_cnt", pkt_cnt, 5);

        // Back-to-back single-word packets until the packet counter wraps.
        for (int i = 0; i < 65536; i++) begin
            push_word({1'b1, 8'($urandom)});
            cycle(1'b1);
        end
        drain();
        check_eq("t6_wrap_cnt", pkt_cnt, 5);

        // Randomized traffic with one mid-run reset.
        gen_left = 0;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 15) != 0);
            if (c == 1500) begin
                fq.delete();
                do_reset();
            end
            if (fq.size() < 16 && $urandom_range(0, 2) != 0) begin
                if (gen_left == 0) gen_left = $urandom_range(1, 6);
                w = {1'b0, 8'($urandom)};
                if (gen_left == 1) w[8] = ($urandom_range(0, 7) != 0);
                gen_left--;
                push_word(w);
            end
            cycle(1'b1);
        end
        push_word(9'h1FF);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
